// File: rtl/mem_port_arb.sv
// Round-robin arbiter/sequencer for the shared unified memory port (fetch vs load/store).
// Optional MEM_PORT_ARB_LOCK_EN: d_lock keeps the port with the data requester across accesses.
module mem_port_arb #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_valid,
  input  logic [31:0]  i_adr,
  output logic         i_ready,
  output logic         i_rvalid,
  output logic [31:0]  i_rdata,
  input  logic         d_valid,
  input  logic [N-1:0] d_adr,
  input  logic [1:0]   d_wtype,
  input  logic         d_rtype,
  input  logic [N-1:0] d_wdata,
  input  logic         d_lock,
  output logic         d_ready,
  output logic         d_rvalid,
  output logic [N-1:0] d_rdata,
  output logic         mem_en,
  output logic [1:0]   mem_we,
  output logic [N-1:0] mem_adr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t         state, state_nx;
  logic [N-1:0]   adr_q, wdata_q;
  logic [1:0]     we_q;
  logic           rtype_q, owner_q, last_grant;
  logic           grant_i, grant_d, locked;
  logic [31:0]    half;

`ifdef MEM_PORT_ARB_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q <= 1'b0;
      locked <= 1'b0;
    end else begin
      if (d_ready) lock_q <= d_lock;
      // lock state follows the flag of each completing data access
      if (state == RESP && owner_q == OWN_D) locked <= lock_q;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = d_lock;
  assign locked      = 1'b0;
`endif

  // data wins unless fetch alone, or data went last on a tie; lock shuts fetch out
  assign grant_d = d_valid & (~i_valid | (last_grant == OWN_I) | locked);
  assign grant_i = i_valid & ~grant_d & ~locked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      adr_q      <= '0;
      wdata_q    <= '0;
      we_q       <= 2'd0;
      rtype_q    <= 1'b0;
      owner_q    <= OWN_I;
      last_grant <= OWN_I;
    end else begin
      state <= state_nx;
      if (d_ready) begin
        adr_q      <= d_adr;
        wdata_q    <= d_wdata;
        we_q       <= d_wtype;
        rtype_q    <= d_rtype;
        owner_q    <= OWN_D;
        last_grant <= OWN_D;
      end else if (i_ready) begin
        adr_q      <= {{(N-32){1'b0}}, i_adr};
        wdata_q    <= '0;
        we_q       <= 2'd0;
        rtype_q    <= 1'b0;
        owner_q    <= OWN_I;
        last_grant <= OWN_I;
      end
    end
  end

  // big-endian: address bit 2 clear selects the upper half
  assign half = adr_q[2] ? mem_rdata[31:0] : mem_rdata[63:32];

  always_comb begin
    state_nx  = state;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    mem_en    = 1'b0;
    mem_we    = 2'd0;
    mem_adr   = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        i_ready = reset_n & grant_i;
        d_ready = reset_n & grant_d;
        if (i_ready || d_ready) state_nx = ACC;
      end
      ACC: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_adr   = adr_q;
        mem_wdata = wdata_q;
        state_nx  = RESP;
      end
      RESP: begin
        if (owner_q == OWN_I) begin
          i_rvalid = 1'b1;
          i_rdata  = half;
        end else begin
          d_rvalid = 1'b1;
          if (we_q == 2'd0) d_rdata = rtype_q ? mem_rdata : {{(N-32){1'b0}}, half};
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed, table-driven bench for mem_port_arb with a registered big-endian memory model.
module tb_mem_port_arb;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_valid, i_ready, i_rvalid;
  logic [31:0]  i_adr, i_rdata;
  logic         d_valid, d_rtype, d_lock, d_ready, d_rvalid;
  logic [1:0]   d_wtype;
  logic [N-1:0] d_adr, d_wdata, d_rdata;
  logic         mem_en;
  logic [1:0]   mem_we;
  logic [N-1:0] mem_adr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arb #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_valid(i_valid), .i_adr(i_adr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_adr(d_adr), .d_wtype(d_wtype), .d_rtype(d_rtype), .d_wdata(d_wdata),
    .d_lock(d_lock), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // registered memory, read-before-write, big-endian byte lanes
  logic [63:0] mem [0:7];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem[mem_adr[5:3]];
      case (mem_we)
        2'd1: if (mem_adr[2]) mem[mem_adr[5:3]][31:0] <= mem_wdata[31:0];
              else            mem[mem_adr[5:3]][63:32] <= mem_wdata[31:0];
        2'd2: mem[mem_adr[5:3]][8*(7-int'(mem_adr[2:0])) +: 8] <= mem_wdata[7:0];
        2'd3: mem[mem_adr[5:3]] <= mem_wdata;
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [1:0]  dw;
    logic        dr;
    logic [63:0] dd;
    logic        dl;
    logic        own;   // 1 = data requester expected to win
    logic [63:0] madr;
    logic [1:0]  mwe;
    logic [63:0] mwd;
    logic [63:0] rdata;
  } vec_t;

  function automatic vec_t mk(input string n, input logic iv, input logic [31:0] ia,
                              input logic dv, input logic [63:0] da, input logic [1:0] dw,
                              input logic dr, input logic [63:0] dd, input logic dl,
                              input logic own, input logic [63:0] rdata);
    vec_t v;
    v.name = n; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dw = dw; v.dr = dr;
    v.dd = dd; v.dl = dl; v.own = own; v.rdata = rdata;
    v.madr = own ? da : {32'h0, ia};
    v.mwe  = own ? dw : 2'd0;
    v.mwd  = own ? dd : 64'h0;
    return v;
  endfunction

  // entered and left at posedge+1 with the arbiter idle
  task automatic run_vec(input vec_t v);
    i_valid = v.iv; i_adr = v.ia;
    d_valid = v.dv; d_adr = v.da; d_wtype = v.dw; d_rtype = v.dr; d_wdata = v.dd; d_lock = v.dl;
    #1;
    chk({v.name, ".i_ready"}, 64'(i_ready), 64'(!v.own));
    chk({v.name, ".d_ready"}, 64'(d_ready), 64'(v.own));
    @(posedge clk); #1;
    chk({v.name, ".acc_mem_en"}, 64'(mem_en), 64'd1);
    chk({v.name, ".acc_mem_adr"}, mem_adr, v.madr);
    chk({v.name, ".acc_mem_we"}, 64'(mem_we), 64'(v.mwe));
    chk({v.name, ".acc_mem_wdata"}, mem_wdata, v.mwd);
    chk({v.name, ".acc_ready"}, 64'({i_ready, d_ready}), 64'd0);
    @(posedge clk); #1;
    chk({v.name, ".resp_rvalid"}, 64'({i_rvalid, d_rvalid}), v.own ? 64'd1 : 64'd2);
    chk({v.name, ".resp_rdata"}, v.own ? d_rdata : 64'(i_rdata), v.rdata);
    chk({v.name, ".resp_ready_en"}, 64'({i_ready, d_ready, mem_en}), 64'd0);
    @(posedge clk); #1;
    i_valid = 1'b0; d_valid = 1'b0;
    chk({v.name, ".idle_rvalid"}, 64'({i_rvalid, d_rvalid}), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ready"}, 64'({i_ready, d_ready}), 64'd0);
    chk({tag, ".rvalid"}, 64'({i_rvalid, d_rvalid}), 64'd0);
    chk({tag, ".mem_en_we"}, 64'({mem_en, mem_we}), 64'd0);
    chk({tag, ".mem_adr"}, mem_adr, 64'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, ".rdata"}, d_rdata | 64'(i_rdata), 64'd0);
  endtask

  vec_t tbl [11];
  vec_t tie_d, tie_i, v;

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = 64'h0;
    mem[0] = 64'h1122_3344_5566_7788;
    mem[1] = 64'hDEAD_BEEF_0000_0001;
    mem[4] = 64'h0123_4567_89AB_CDEF;

    tbl[0]  = mk("fetch4",   1, 32'h4,  0, 64'h0,  0, 0, 64'h0, 0, 0, 64'h5566_7788);
    tbl[1]  = mk("fetch0",   1, 32'h0,  0, 64'h0,  0, 0, 64'h0, 0, 0, 64'h1122_3344);
    tbl[2]  = mk("bytewr13", 0, 32'h0,  1, 64'h13, 2, 0, 64'hAB, 0, 1, 64'h0);
    tbl[3]  = mk("dwrd10",   0, 32'h0,  1, 64'h10, 0, 1, 64'h0, 0, 1, 64'h0000_00AB_0000_0000);
    tbl[4]  = mk("wrd8",     0, 32'h0,  1, 64'h8,  0, 0, 64'h0, 0, 1, 64'h0000_0000_DEAD_BEEF);
    tbl[5]  = mk("wrdC",     0, 32'h0,  1, 64'hC,  0, 0, 64'h0, 0, 1, 64'h0000_0000_0000_0001);
    tbl[6]  = mk("wrdwr14",  0, 32'h0,  1, 64'h14, 1, 0, 64'hFFFF_FFFF_CAFE_F00D, 0, 1, 64'h0);
    tbl[7]  = mk("dwrd10b",  0, 32'h0,  1, 64'h10, 0, 1, 64'h0, 0, 1, 64'h0000_00AB_CAFE_F00D);
    tbl[8]  = mk("dwwr18",   0, 32'h0,  1, 64'h18, 3, 0, 64'h0102_0304_0506_0708, 0, 1, 64'h0);
    tbl[9]  = mk("wrd1C",    0, 32'h0,  1, 64'h1C, 0, 0, 64'h0, 0, 1, 64'h0000_0000_0506_0708);
    tbl[10] = mk("fetch18",  1, 32'h18, 0, 64'h0,  0, 0, 64'h0, 0, 0, 64'h0102_0304);

    // reset with both requesters pushing: nothing may be granted
    reset_n = 1'b0;
    i_valid = 1'b1; i_adr = 32'h4;
    d_valid = 1'b1; d_adr = 64'h8; d_wtype = 2'd3; d_rtype = 1'b1; d_wdata = '1; d_lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1; i_valid = 1'b0; d_valid = 1'b0;

    foreach (tbl[k]) run_vec(tbl[k]);

    // tie held over four grants from reset: D, I, D, I
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tie_d = mk("tieD", 1, 32'h0, 1, 64'h8, 0, 1, 64'h0, 0, 1, 64'hDEAD_BEEF_0000_0001);
    tie_i = mk("tieI", 1, 32'h0, 1, 64'h8, 0, 1, 64'h0, 0, 0, 64'h1122_3344);
    for (int g = 0; g < 4; g++) run_vec((g % 2 == 0) ? tie_d : tie_i);

    // reset during ACC of a doubleword write: no commit, no response
    d_valid = 1'b1; d_adr = 64'h20; d_wtype = 2'd3; d_rtype = 1'b0; d_wdata = '1; d_lock = 1'b0;
    #1;
    chk("abort.d_ready", 64'(d_ready), 64'd1);
    @(posedge clk); #1;
    chk("abort.acc_mem_en", 64'(mem_en), 64'd1);
    d_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_all_zero("abort");
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("abort.no_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
    end
    reset_n = 1'b1;
    run_vec(mk("abort_rd20", 0, 32'h0, 1, 64'h20, 0, 1, 64'h0, 0, 1, 64'h0123_4567_89AB_CDEF));

    // lock: locked read, then ties; last_grant is D here
    run_vec(mk("lock1", 0, 32'h0, 1, 64'h8, 0, 1, 64'h0, 1, 1, 64'hDEAD_BEEF_0000_0001));
`ifdef MEM_PORT_ARB_LOCK_EN
    v = mk("lock2", 1, 32'h4, 1, 64'h0, 0, 1, 64'h0, 0, 1, 64'h1122_3344_5566_7788);
    run_vec(v);
    v = mk("lock3", 1, 32'h4, 1, 64'h0, 0, 1, 64'h0, 0, 0, 64'h5566_7788);
    run_vec(v);
`else
    v = mk("lock2", 1, 32'h4, 1, 64'h0, 0, 1, 64'h0, 0, 0, 64'h5566_7788);
    run_vec(v);
    v = mk("lock3", 1, 32'h4, 1, 64'h0, 0, 1, 64'h0, 0, 1, 64'h1122_3344_5566_7788);
    run_vec(v);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester arbiter and sequencer for the shared 64-bit unified instruction/data memory of the MIPS core. It accepts instruction-fetch and load/store requests over valid/ready handshakes and grants one at a time, round-robin. It drives the single synchronous memory port and returns read data to the granted requester. The memory side uses the existing write encoding: 0 none, 1 word, 2 byte, 3 doubleword, big-endian within the 64-bit word.

## Interface
- N, 64: data/address width of the data requester and memory port.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  instruction fetch request.
- i_adr  in  32  fetch byte address.
- i_ready  out  1  fetch accepted this cycle when i_valid & i_ready.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  32  fetched instruction.
- d_valid  in  1  data request.
- d_adr  in  N  data byte address.
- d_wtype  in  2  write type (0 read, 1 word, 2 byte, 3 doubleword).
- d_rtype  in  1  read size: 1 doubleword, 0 word zero-extended.
- d_wdata  in  N  write data.
- d_lock  in  1  keep data ownership after this access (see Configuration).
- d_ready  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: access complete; d_rdata valid for reads.
- d_rdata  out  N  read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  2  write type to memory (same encoding as d_wtype).
- mem_adr  out  N  byte address to memory.
- mem_wdata  out  N  write data to memory.
- mem_rdata  in  N  memory read data, registered by memory, valid the cycle after mem_en.

## Operation
- FSM states: IDLE, ACC, RESP. Reset state IDLE.
- IDLE: i_ready/d_ready asserted combinationally per arbitration. Only one ready is high in a cycle. With one valid, that requester wins. With both valid, the requester not in last_grant wins.
- On acceptance: latch adr, wtype, rtype, wdata and owner (I or D); last_grant <= owner; go to ACC.
- ACC: mem_en=1; mem_adr/mem_we/mem_wdata from latches. Fetches use mem_we=0 and mem_adr={{N-32{0}},i_adr}. Go to RESP.
- RESP: pulse owner's rvalid, then go to IDLE.
  - Fetch: i_rdata = i_adr[2] ? mem_rdata[31:0] : mem_rdata[63:32].
  - Data read: d_rdata = d_rtype ? mem_rdata : {32'b0, adr[2] ? low half : high half}.
  - Data write: d_rdata = 0.
- Ready is low in ACC and RESP; exactly one outstanding access.
- Address low bits pass through unmodified. Alignment is the requester's responsibility.
- last_grant reset value: I. On the first tie, data wins.

## Timing
- Acceptance edge T → mem_en high in cycle T+1 → rvalid high in cycle T+2 → new acceptance possible at the edge ending T+3. Throughput is 1 access per 3 cycles.
- Writes commit at the edge ending cycle T+1.
- rdata outputs are combinational from mem_rdata during RESP and 0 otherwise.
- Reset values: i_ready=d_ready=0 while reset_n=0; i_rvalid=d_rvalid=0; mem_en=0; mem_we=0; mem_adr=0; mem_wdata=0; i_rdata=d_rdata=0; last_grant=I; lock flag=0.
- Reset asserted mid-operation:
  - Outputs drop immediately (asynchronous), including mem_en in ACC, so no write commits.
  - No rvalid is issued for the aborted request; the requester must reissue it.
- Requester valid deasserted before acceptance: no effect, no access.
- Payload inputs matter only at the acceptance edge.

## Configuration
- MEM_PORT_ARB_LOCK_EN defined:
  - d_lock is latched at data acceptance.
  - If set, after RESP the arbiter enters locked mode: i_ready held 0 and only data requests are granted.
  - Locked mode ends at the RESP of a data access accepted with d_lock=0.
  - Reset clears locked mode.
  - Intended for read-modify-write sequences.
- Undefined: d_lock is ignored and pure round-robin always applies.

## Test plan
- Fetch only: i_adr=0x0000_0004, memory word 0x1122_3344_5566_7788 → mem_en at T+1 with mem_adr=4, mem_we=0; i_rvalid at T+2 with i_rdata=0x5566_7788.
- Data byte write then doubleword read: d_adr=0x13, d_wtype=2, d_wdata=0xAB → mem_we=2, mem_adr=0x13. Then read d_adr=0x10, d_rtype=1 → d_rdata bits[39:32]=0xAB.
- Word read zero-extended: d_adr=0x8, d_rtype=0, word 0xDEAD_BEEF_0000_0001 → d_rdata=0x0000_0000_DEAD_BEEF.
- Simultaneous i_valid and d_valid held 4 grants from reset → grant order D, I, D, I, with no ready in ACC/RESP cycles.
- reset_n low in ACC of a doubleword write to 0x20 → mem_en falls immediately; memory at 0x20 unchanged; no d_rvalid; all outputs 0.
- With MEM_PORT_ARB_LOCK_EN: d_lock=1 read, then both valid → data granted again, i_ready=0. After a d_lock=0 data access completes, the next grant goes to I. Without the macro, the second grant goes to I.
